// File: rtl/odev1_sweep.sv
// ---------------------------------------------------------------------------
// odev1_sweep
//   Stimulus sequencer and response collector for a 3-input f/q logic stage.
//
//   When start is seen in IDLE, the block walks {a,b,c} through all eight
//   input vectors. The order is binary, or Gray when GRAY_ORDER=1. Each vector
//   is held for SETTLE_CYCLES+1 cycles. On the last of those cycles the looped
//   back f/q response is captured into f_table/q_table, indexed by the vector
//   value. After the eighth capture the block pulses done for one cycle and
//   returns to IDLE.
//
//   Optional feature (macro ODEV1_SWEEP_CHECK_EN):
//     When defined, pass is registered in the DONE cycle. It is 1 when the
//     final tables equal the reference stage response (f=8'h4B, q=8'h00).
//     When undefined, pass is tied low and no compare logic is built.
//
//   Ports:
//     clk      in   clock, all state on rising edge
//     rst_n    in   synchronous active-low reset
//     start    in   sweep request, honoured only in IDLE
//     f_in     in   f response of the downstream stage
//     q_in     in   q response of the downstream stage
//     a,b,c    out  registered stimulus vector {a,b,c}
//     busy     out  high while vectors are being driven
//     done     out  one-cycle completion pulse
//     f_table  out  captured f per vector index
//     q_table  out  captured q per vector index
//     pass     out  self-check result (see macro above)
// ---------------------------------------------------------------------------
module odev1_sweep #(
  parameter int SETTLE_CYCLES = 1,
  parameter int GRAY_ORDER    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  input  logic       q_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] f_table,
  output logic [7:0] q_table,
  output logic       pass
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t     stateReg, stateNext;
  logic [2:0] stepReg;
  logic [3:0] settleReg;
  logic [2:0] vecReg;
  logic       doneReg;
  logic       acceptStart;
  logic       sampleNow;

  // Map a step number to the vector that is driven for it.
  function automatic logic [2:0] seqOf(input logic [2:0] s);
    if (GRAY_ORDER != 0) return s ^ (s >> 1);
    else                 return s;
  endfunction

  always_comb begin
    stateNext   = stateReg;
    acceptStart = 1'b0;
    sampleNow   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) begin
          acceptStart = 1'b1;
          stateNext   = DRIVE;
        end
      end
      DRIVE: begin
        // The capture edge is the one that ends the final hold cycle.
        if (settleReg == SETTLE_LAST) begin
          sampleNow = 1'b1;
          if (stepReg == 3'd7) stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      stepReg   <= 3'd0;
      settleReg <= 4'd0;
      vecReg    <= 3'd0;
      doneReg   <= 1'b0;
      f_table   <= 8'h00;
      q_table   <= 8'h00;
    end else begin
      stateReg <= stateNext;
      // done is registered so that it is high exactly while in DONE.
      doneReg  <= (stateNext == DONE);

      if (acceptStart) begin
        stepReg   <= 3'd0;
        settleReg <= 4'd0;
        vecReg    <= seqOf(3'd0);
        f_table   <= 8'h00;
        q_table   <= 8'h00;
      end else if (stateReg == DRIVE) begin
        if (sampleNow) begin
          f_table[seqOf(stepReg)] <= f_in;
          q_table[seqOf(stepReg)] <= q_in;
          stepReg   <= stepReg + 3'd1;
          settleReg <= 4'd0;
          // The vector for the next step is loaded on the same edge as the
          // capture, so every vector gets the full hold time.
          if (stepReg == 3'd7) vecReg <= 3'd0;
          else                 vecReg <= seqOf(stepReg + 3'd1);
        end else begin
          settleReg <= settleReg + 4'd1;
        end
      end else begin
        vecReg <= 3'd0;
      end
    end
  end

`ifdef ODEV1_SWEEP_CHECK_EN
  logic passReg;

  // The tables are final in the DONE cycle, because the last capture happened
  // on the edge that entered DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      passReg <= 1'b0;
    end else if (acceptStart) begin
      passReg <= 1'b0;
    end else if (stateReg == DONE) begin
      passReg <= (f_table == 8'h4B) && (q_table == 8'h00);
    end
  end

  assign pass = passReg;
`else
  assign pass = 1'b0;
`endif

  assign a    = vecReg[2];
  assign b    = vecReg[1];
  assign c    = vecReg[0];
  assign busy = (stateReg == DRIVE);
  assign done = doneReg;

endmodule

// File: tb/tb_odev1_sweep.sv
// ---------------------------------------------------------------------------
// tb_odev1_sweep
//   Self-checking bench for odev1_sweep. It runs three instances:
//     inst 0: SETTLE_CYCLES=1, binary order
//     inst 1: SETTLE_CYCLES=1, Gray order
//     inst 2: SETTLE_CYCLES=0, binary order
//   Each instance is fed by a behavioural f/q stage, which is a truth-table
//   lookup on {a,b,c}. Expected vector order, timing, tables and pass are
//   derived from the sweep rules.
// ---------------------------------------------------------------------------
module tb_odev1_sweep;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [N-1:0]        startV;
  logic [N-1:0]        aV, bV, cV, busyV, doneV, passV, fInV, qInV;
  logic [N-1:0][7:0]   fTableV, qTableV;
  logic [N-1:0][7:0]   fTab, qTab;

  int nTests = 0;
  int nFail  = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    // Behavioural model of the downstream combinational f/q stage.
    assign fInV[gi] = fTab[gi][{aV[gi], bV[gi], cV[gi]}];
    assign qInV[gi] = qTab[gi][{aV[gi], bV[gi], cV[gi]}];

    odev1_sweep #(
      .SETTLE_CYCLES((gi == 2) ? 0 : 1),
      .GRAY_ORDER   ((gi == 1) ? 1 : 0)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (startV[gi]),
      .f_in    (fInV[gi]),
      .q_in    (qInV[gi]),
      .a       (aV[gi]),
      .b       (bV[gi]),
      .c       (cV[gi]),
      .busy    (busyV[gi]),
      .done    (doneV[gi]),
      .f_table (fTableV[gi]),
      .q_table (qTableV[gi]),
      .pass    (passV[gi])
    );
  end

  function automatic int settleOf(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic logic expPassOf(input logic [7:0] fT, input logic [7:0] qT);
`ifdef ODEV1_SWEEP_CHECK_EN
    return (fT == 8'h4B) && (qT == 8'h00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    startV = '0;
    repeat (2) @(negedge clk);
    nTests++;
    if ({aV, bV, cV, busyV, doneV, passV, fTableV, qTableV} !== '0) begin
      nFail++;
      $display("FAIL reset_state: got abc/busy/done/pass=%b%b%b/%b/%b/%b ftab=%h qtab=%h, want all 0",
               aV, bV, cV, busyV, doneV, passV, fTableV, qTableV);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset checked");
  endtask

  // Runs one sweep on instance k with stage tables fT/qT. If repulse is set,
  // start is pulsed again in the middle of DRIVE and during DONE.
  task automatic test_sweep(input int k, input logic [7:0] fT, input logic [7:0] qT,
                            input bit repulse, input string name);
    int       s    = settleOf(k);
    int       last = 8 * (s + 1);
    int       order[8];
    logic [4:0] got, exp;
    if (k == 1) order = '{0, 1, 3, 2, 6, 7, 5, 4};
    else        order = '{0, 1, 2, 3, 4, 5, 6, 7};
    fTab[k] = fT;
    qTab[k] = qT;
    @(negedge clk);
    startV[k] = 1'b1;                      // accepted at the next edge (E0)
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      got = {busyV[k], doneV[k], aV[k], bV[k], cV[k]};
      if (n <= last) exp = {1'b1, 1'b0, 3'(order[(n - 1) / (s + 1)])};
      else           exp = 5'b01000;
      nTests++;
      if (got !== exp) begin
        nFail++;
        $display("FAIL %s_cycle%0d: busy,done,abc got %b want %b", name, n, got, exp);
      end
      startV[k] = repulse && (n == 3 || n == last + 1);
    end
    @(negedge clk);
    startV[k] = 1'b0;
    nTests++;
    if (doneV[k] !== 1'b0) begin
      nFail++;
      $display("FAIL %s_done_width: done got %b want 0", name, doneV[k]);
    end
    nTests++;
    if (fTableV[k] !== fT || qTableV[k] !== qT) begin
      nFail++;
      $display("FAIL %s_tables: got f=%h q=%h want f=%h q=%h", name, fTableV[k], qTableV[k], fT, qT);
    end
    nTests++;
    if (passV[k] !== expPassOf(fT, qT)) begin
      nFail++;
      $display("FAIL %s_pass: got %b want %b", name, passV[k], expPassOf(fT, qT));
    end
    // No restart may follow from the ignored start pulses.
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      nTests++;
      if (busyV[k] !== 1'b0 || doneV[k] !== 1'b0) begin
        nFail++;
        $display("FAIL %s_idle%0d: busy/done got %b/%b want 0/0", name, n, busyV[k], doneV[k]);
      end
    end
    $display("[TB] sweep %s inst %0d f=%h q=%h", name, k, fT, qT);
  endtask

  task automatic test_back_to_back();
    logic [7:0] fT = 8'($urandom);
    logic [7:0] qT = 8'($urandom);
    fTab[2] = fT;
    qTab[2] = qT;
    @(negedge clk);
    startV[2] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      nTests++;
      if (doneV[2] !== ((n % 10) == 9)) begin
        nFail++;
        $display("FAIL b2b_done_cycle%0d: done got %b want %b", n, doneV[2], (n % 10) == 9);
      end
    end
    startV[2] = 1'b0;
    @(negedge clk);
    nTests++;
    if (fTableV[2] !== fT || qTableV[2] !== qT || busyV[2] !== 1'b0) begin
      nFail++;
      $display("FAIL b2b_end: got f=%h q=%h busy=%b want f=%h q=%h busy=0",
               fTableV[2], qTableV[2], busyV[2], fT, qT);
    end
    $display("[TB] back-to-back sweeps inst 2 f=%h q=%h", fT, qT);
  endtask

  task automatic test_reset_midsweep();
    fTab[0] = 8'hFF;
    qTab[0] = 8'hFF;
    @(negedge clk);
    startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nTests++;
    if ({aV, bV, cV, busyV, doneV, passV, fTableV, qTableV} !== '0) begin
      nFail++;
      $display("FAIL midsweep_reset: got abc/busy/done/pass=%b%b%b/%b/%b/%b ftab=%h qtab=%h, want all 0",
               aV, bV, cV, busyV, doneV, passV, fTableV, qTableV);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      nTests++;
      if (doneV[0] !== 1'b0 || busyV[0] !== 1'b0) begin
        nFail++;
        $display("FAIL midsweep_after%0d: busy/done got %b/%b want 0/0", n, busyV[0], doneV[0]);
      end
    end
    $display("[TB] reset during sweep inst 0");
  endtask

  initial begin
    fTab = '0;
    qTab = '0;
    test_reset();
    test_sweep(0, 8'h4B, 8'h00, 1'b0, "binary_ref");
    test_sweep(1, 8'h4B, 8'h00, 1'b0, "gray_ref");
    test_sweep(2, 8'h4B, 8'h00, 1'b0, "settle0_ref");
    test_sweep(0, 8'hFF, 8'hFF, 1'b0, "ones");
    for (int r = 0; r < 6; r++)
      test_sweep(r % N, 8'($urandom), 8'($urandom), 1'b0, "random");
    test_sweep(0, 8'($urandom), 8'($urandom), 1'b1, "repulse");
    test_sweep(1, 8'h4B, 8'h00, 1'b1, "repulse_gray");
    test_back_to_back();
    test_reset_midsweep();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
